spi_bus_arbiter: RTL and testbench

Shares one single-port register memory between the SPI slave's internal bus and a local host port. The SPI side cannot be stalled, so it always takes priority. The arbiter keeps a read-data shadow register that tracks the SPI bus address, and it runs the memory with a 1-cycle read latency. It sits between the SPI slave top level and the register RAM.

---
 rtl/spi_bus_arbiter.sv | 145 ++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bus_arbiter.sv
// Arbitrates a single-port register RAM between the SPI slave bus (never stalled)
// and a host req/ack port, keeping a read-data shadow of mem[spi address].
module spi_bus_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_spi_addr,
  input  logic [DATA_W-1:0] i_spi_wdata,
  input  logic              i_spi_wr,
  output logic [DATA_W-1:0] o_spi_rdata,
  output logic              o_spi_overrun,
  input  logic              i_host_req,
  input  logic              i_host_we,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DATA_W-1:0] i_host_wdata,
  output logic              o_host_ack,
  output logic [DATA_W-1:0] o_host_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [2:0]        o_dbg_state
);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_SPI_WR      = 3'd1;
  localparam logic [2:0] S_SPI_RD      = 3'd2;
  localparam logic [2:0] S_SPI_RD_WAIT = 3'd3;
  localparam logic [2:0] S_HOST_ACC    = 3'd4;
  localparam logic [2:0] S_HOST_DONE   = 3'd5;

  logic [2:0]        state, state_d;
  logic [ADDR_W-1:0] spi_addr_q;
  logic              rd_pend, wr_pend;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              host_we_q;
  logic [ADDR_W-1:0] host_addr_q;
  logic [DATA_W-1:0] host_wdata_q;
  logic              host_grant;
  logic              rd_set;

  assign o_dbg_state = state;

  // Host handshake: i_host_req is held until the one-cycle o_host_ack pulse;
  // command fields are sampled on grant, and the ack cycle never re-grants.
  assign host_grant = (state == S_IDLE) && !wr_pend && !rd_pend &&
                      i_host_req && !o_host_ack;

  // Any event that may leave the shadow stale schedules a refresh read.
  assign rd_set = (i_spi_addr != spi_addr_q) ||
                  ((state == S_SPI_WR) && (wr_addr == spi_addr_q)) ||
                  ((state == S_HOST_ACC) && host_we_q && (host_addr_q == spi_addr_q));

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (wr_pend)         state_d = S_SPI_WR;
        else if (rd_pend)    state_d = S_SPI_RD;
        else if (host_grant) state_d = S_HOST_ACC;
      end
      S_SPI_WR:      state_d = S_IDLE;
      S_SPI_RD:      state_d = S_SPI_RD_WAIT;
      S_SPI_RD_WAIT: state_d = S_IDLE;
      S_HOST_ACC:    state_d = S_HOST_DONE;
      S_HOST_DONE:   state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    case (state)
      S_SPI_WR: begin
        o_mem_en    = 1'b1;
        o_mem_we    = 1'b1;
        o_mem_addr  = wr_addr;
        o_mem_wdata = wr_data;
      end
      S_SPI_RD: begin
        o_mem_en   = 1'b1;
        o_mem_addr = spi_addr_q;
      end
      S_HOST_ACC: begin
        o_mem_en    = 1'b1;
        o_mem_we    = host_we_q;
        o_mem_addr  = host_addr_q;
        o_mem_wdata = host_wdata_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= S_IDLE;
      spi_addr_q    <= '0;
      rd_pend       <= 1'b1;
      wr_pend       <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      host_we_q     <= 1'b0;
      host_addr_q   <= '0;
      host_wdata_q  <= '0;
      o_spi_rdata   <= '0;
      o_spi_overrun <= 1'b0;
      o_host_ack    <= 1'b0;
      o_host_rdata  <= '0;
    end else begin
      state      <= state_d;
      spi_addr_q <= i_spi_addr;
      // A new address arriving during the refresh wins over the clear.
      rd_pend    <= rd_set || (rd_pend && (state != S_SPI_RD));

      // A write landing in SPI_WR replaces a buffer already being written, so nothing is lost.
      if (i_spi_wr) begin
        wr_pend <= 1'b1;
        wr_addr <= i_spi_addr;
        wr_data <= i_spi_wdata;
        if (wr_pend && (state != S_SPI_WR)) o_spi_overrun <= 1'b1;
      end else if (state == S_SPI_WR) begin
        wr_pend <= 1'b0;
      end

      if (host_grant && !wr_pend && !rd_pend) begin
        host_we_q    <= i_host_we;
        host_addr_q  <= i_host_addr;
        host_wdata_q <= i_host_wdata;
      end

      if (state == S_SPI_RD_WAIT) o_spi_rdata <= i_mem_rdata;

      o_host_ack <= (state == S_HOST_DONE);
      if ((state == S_HOST_DONE) && !host_we_q) o_host_rdata <= i_mem_rdata;
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter with a 1-cycle-latency RAM model and an access log.
module tb_spi_bus_arbiter;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic [7:0] i_spi_addr, i_spi_wdata;
  logic       i_spi_wr;
  logic [7:0] o_spi_rdata;
  logic       o_spi_overrun;
  logic       i_host_req, i_host_we;
  logic [7:0] i_host_addr, i_host_wdata;
  logic       o_host_ack;
  logic [7:0] o_host_rdata;
  logic       o_mem_en, o_mem_we;
  logic [7:0] o_mem_addr, o_mem_wdata;
  logic [7:0] mem_rdata;
  logic [2:0] o_dbg_state;

  int pass_cnt = 0;
  int check_cnt = 0;

  // RAM model and access log {we, addr, wdata}
  logic [7:0]  mem [256];
  logic [16:0] acc_q[$];
  int          ack_cnt = 0;
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = 8'h0, pre_data = 8'h0;

  // clock/reset block
  always #5 i_clk = ~i_clk;

  spi_bus_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_spi_addr(i_spi_addr), .i_spi_wdata(i_spi_wdata), .i_spi_wr(i_spi_wr),
    .o_spi_rdata(o_spi_rdata), .o_spi_overrun(o_spi_overrun),
    .i_host_req(i_host_req), .i_host_we(i_host_we), .i_host_addr(i_host_addr),
    .i_host_wdata(i_host_wdata), .o_host_ack(o_host_ack), .o_host_rdata(o_host_rdata),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(mem_rdata), .o_dbg_state(o_dbg_state)
  );

  always @(posedge i_clk) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (o_mem_en) begin
      if (o_mem_we) begin
        mem[o_mem_addr] <= o_mem_wdata;
        acc_q.push_back({1'b1, o_mem_addr, o_mem_wdata});
      end else begin
        mem_rdata <= mem[o_mem_addr];
        acc_q.push_back({1'b0, o_mem_addr, 8'h00});
      end
    end
    if (o_host_ack) ack_cnt <= ack_cnt + 1;
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    tick(1);
    pre_we   = 1'b0;
  endtask

  function automatic logic [16:0] get_acc(input int idx);
    if (idx < acc_q.size()) return acc_q[idx];
    return 17'h1FFFF;
  endfunction

  task automatic test_reset();
    i_reset = 1'b1;
    tick(2);
    preload(8'h00, 8'h5A);
    preload(8'h10, 8'hC3);
    preload(8'h05, 8'h11);
    preload(8'h07, 8'h3C);
    preload(8'h20, 8'h00);
    preload(8'h06, 8'h00);
    preload(8'h30, 8'h00);
    check_cnt++; if (o_spi_rdata !== 8'h00) $display("FAIL rst_spi_rdata: got %h want 00", o_spi_rdata); else pass_cnt++;
    check_cnt++; if (o_spi_overrun !== 1'b0) $display("FAIL rst_overrun: got %b want 0", o_spi_overrun); else pass_cnt++;
    check_cnt++; if (o_host_ack !== 1'b0) $display("FAIL rst_ack: got %b want 0", o_host_ack); else pass_cnt++;
    check_cnt++; if (o_host_rdata !== 8'h00) $display("FAIL rst_host_rdata: got %h want 00", o_host_rdata); else pass_cnt++;
    check_cnt++; if ({o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata} !== 18'h0)
      $display("FAIL rst_mem_if: got en=%b we=%b a=%h d=%h want all 0", o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata); else pass_cnt++;
    check_cnt++; if (o_dbg_state !== 3'd0) $display("FAIL rst_state: got %0d want 0", o_dbg_state); else pass_cnt++;
    i_reset = 1'b0;
    tick(2);
    check_cnt++; if (o_spi_rdata !== 8'h00) $display("FAIL rst_shadow_early: got %h want 00", o_spi_rdata); else pass_cnt++;
    tick(2);
    check_cnt++; if (o_spi_rdata !== 8'h5A) $display("FAIL rst_shadow_load: got %h want 5a", o_spi_rdata); else pass_cnt++;
    check_cnt++; if (o_mem_en !== 1'b0) $display("FAIL rst_idle_en: got %b want 0", o_mem_en); else pass_cnt++;
  endtask

  task automatic test_spi_read();
    int base;
    base = acc_q.size();
    i_spi_addr = 8'h10;
    tick(3);
    check_cnt++; if (o_spi_rdata !== 8'h5A) $display("FAIL rd_latency: got %h want 5a", o_spi_rdata); else pass_cnt++;
    tick(1);
    check_cnt++; if (o_spi_rdata !== 8'hC3) $display("FAIL rd_data: got %h want c3", o_spi_rdata); else pass_cnt++;
    tick(4);
    check_cnt++; if (acc_q.size() - base !== 1) $display("FAIL rd_count: got %0d want 1", acc_q.size() - base); else pass_cnt++;
    check_cnt++; if (get_acc(base) !== {1'b0, 8'h10, 8'h00}) $display("FAIL rd_access: got %h want 01000", get_acc(base)); else pass_cnt++;
  endtask

  task automatic test_spi_write_same();
    int base;
    i_spi_addr = 8'h20;
    tick(6);
    base = acc_q.size();
    i_spi_wdata = 8'h77;
    i_spi_wr = 1'b1;
    tick(1);
    i_spi_wr = 1'b0;
    tick(7);
    check_cnt++; if (acc_q.size() - base !== 2) $display("FAIL wr_count: got %0d want 2", acc_q.size() - base); else pass_cnt++;
    check_cnt++; if (get_acc(base) !== {1'b1, 8'h20, 8'h77}) $display("FAIL wr_access: got %h want 12077", get_acc(base)); else pass_cnt++;
    check_cnt++; if (get_acc(base + 1) !== {1'b0, 8'h20, 8'h00}) $display("FAIL wr_refresh: got %h want 02000", get_acc(base + 1)); else pass_cnt++;
    check_cnt++; if (o_spi_rdata !== 8'h77) $display("FAIL wr_shadow: got %h want 77", o_spi_rdata); else pass_cnt++;
  endtask

  task automatic test_host_read();
    int base, ack_base, n;
    base = acc_q.size();
    ack_base = ack_cnt;
    i_host_req = 1'b1; i_host_we = 1'b0; i_host_addr = 8'h05; i_host_wdata = 8'hEE;
    n = 0;
    while (n < 20 && o_host_ack !== 1'b1) begin tick(1); n++; end
    check_cnt++; if (n !== 3) $display("FAIL host_rd_latency: got %0d cycles want 3", n); else pass_cnt++;
    check_cnt++; if (o_host_rdata !== 8'h11) $display("FAIL host_rd_data: got %h want 11", o_host_rdata); else pass_cnt++;
    i_host_req = 1'b0;
    tick(4);
    check_cnt++; if (acc_q.size() - base !== 1) $display("FAIL host_rd_single: got %0d accesses want 1", acc_q.size() - base); else pass_cnt++;
    check_cnt++; if (ack_cnt - ack_base !== 1) $display("FAIL host_rd_acks: got %0d want 1", ack_cnt - ack_base); else pass_cnt++;
  endtask

  task automatic test_host_write_refresh();
    int base, n;
    base = acc_q.size();
    i_host_req = 1'b1; i_host_we = 1'b1; i_host_addr = 8'h20; i_host_wdata = 8'hA5;
    n = 0;
    while (n < 20 && o_host_ack !== 1'b1) begin tick(1); n++; end
    check_cnt++; if (n !== 3) $display("FAIL host_wr_latency: got %0d cycles want 3", n); else pass_cnt++;
    i_host_req = 1'b0;
    tick(4);
    check_cnt++; if (o_spi_rdata !== 8'hA5) $display("FAIL host_wr_shadow: got %h want a5", o_spi_rdata); else pass_cnt++;
    check_cnt++; if (get_acc(base + 1) !== {1'b0, 8'h20, 8'h00}) $display("FAIL host_wr_refresh: got %h want 02000", get_acc(base + 1)); else pass_cnt++;
    check_cnt++; if (o_host_rdata !== 8'h11) $display("FAIL host_rdata_hold: got %h want 11", o_host_rdata); else pass_cnt++;
  endtask

  // Request arrives while the SPI write is pending: write, shadow refresh, then host.
  task automatic test_back_to_back();
    int base, n;
    i_spi_addr = 8'h06;
    tick(6);
    base = acc_q.size();
    i_spi_wdata = 8'h99;
    i_spi_wr = 1'b1;
    tick(1);
    i_spi_wr = 1'b0;
    i_host_req = 1'b1; i_host_we = 1'b0; i_host_addr = 8'h05;
    n = 0;
    while (n < 20 && o_host_ack !== 1'b1) begin tick(1); n++; end
    check_cnt++; if (n !== 8) $display("FAIL cont_latency: got %0d cycles want 8", n); else pass_cnt++;
    check_cnt++; if (o_host_rdata !== 8'h11) $display("FAIL cont_host_data: got %h want 11", o_host_rdata); else pass_cnt++;
    check_cnt++; if (o_spi_rdata !== 8'h99) $display("FAIL cont_spi_data: got %h want 99", o_spi_rdata); else pass_cnt++;
    check_cnt++; if (get_acc(base) !== {1'b1, 8'h06, 8'h99}) $display("FAIL cont_first: got %h want 10699", get_acc(base)); else pass_cnt++;
    check_cnt++; if (get_acc(base + 2) !== {1'b0, 8'h05, 8'h00}) $display("FAIL cont_host_acc: got %h want 00500", get_acc(base + 2)); else pass_cnt++;
    i_host_req = 1'b0;
    tick(2);
  endtask

  task automatic test_overrun();
    int base;
    i_spi_addr = 8'h30;
    tick(6);
    base = acc_q.size();
    check_cnt++; if (o_spi_overrun !== 1'b0) $display("FAIL ovr_before: got %b want 0", o_spi_overrun); else pass_cnt++;
    i_host_req = 1'b1; i_host_we = 1'b0; i_host_addr = 8'h07;
    tick(1);
    i_spi_wr = 1'b1; i_spi_wdata = 8'hA1;
    tick(1);
    i_spi_wdata = 8'hA2;
    tick(1);
    i_spi_wr = 1'b0;
    check_cnt++; if (o_host_ack !== 1'b1) $display("FAIL ovr_ack: got %b want 1", o_host_ack); else pass_cnt++;
    check_cnt++; if (o_host_rdata !== 8'h3C) $display("FAIL ovr_host_data: got %h want 3c", o_host_rdata); else pass_cnt++;
    check_cnt++; if (o_spi_overrun !== 1'b1) $display("FAIL ovr_flag: got %b want 1", o_spi_overrun); else pass_cnt++;
    i_host_req = 1'b0;
    tick(6);
    check_cnt++; if (acc_q.size() - base !== 3) $display("FAIL ovr_count: got %0d want 3", acc_q.size() - base); else pass_cnt++;
    check_cnt++; if (get_acc(base + 1) !== {1'b1, 8'h30, 8'hA2}) $display("FAIL ovr_write: got %h want 130a2", get_acc(base + 1)); else pass_cnt++;
    check_cnt++; if (o_spi_rdata !== 8'hA2) $display("FAIL ovr_shadow: got %h want a2", o_spi_rdata); else pass_cnt++;
    tick(10);
    check_cnt++; if (o_spi_overrun !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", o_spi_overrun); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    int ack_base;
    ack_base = ack_cnt;
    i_host_req = 1'b1; i_host_we = 1'b0; i_host_addr = 8'h05;
    tick(1);
    check_cnt++; if (o_dbg_state !== 3'd4) $display("FAIL mr_in_access: got %0d want 4", o_dbg_state); else pass_cnt++;
    i_reset = 1'b1;
    i_spi_addr = 8'h00;
    tick(1);
    check_cnt++; if (o_dbg_state !== 3'd0) $display("FAIL mr_state: got %0d want 0", o_dbg_state); else pass_cnt++;
    check_cnt++; if (o_spi_rdata !== 8'h00) $display("FAIL mr_rdata_clr: got %h want 00", o_spi_rdata); else pass_cnt++;
    check_cnt++; if (o_spi_overrun !== 1'b0) $display("FAIL mr_overrun_clr: got %b want 0", o_spi_overrun); else pass_cnt++;
    tick(1);
    i_reset = 1'b0;
    i_host_req = 1'b0;
    tick(5);
    check_cnt++; if (ack_cnt - ack_base !== 0) $display("FAIL mr_no_ack: got %0d acks want 0", ack_cnt - ack_base); else pass_cnt++;
    check_cnt++; if (o_spi_rdata !== 8'h5A) $display("FAIL mr_reload: got %h want 5a", o_spi_rdata); else pass_cnt++;
    check_cnt++; if (o_dbg_state !== 3'd0) $display("FAIL mr_idle: got %0d want 0", o_dbg_state); else pass_cnt++;
  endtask

  initial begin
    i_reset = 1'b1;
    i_spi_addr = 8'h00; i_spi_wdata = 8'h00; i_spi_wr = 1'b0;
    i_host_req = 1'b0; i_host_we = 1'b0; i_host_addr = 8'h00; i_host_wdata = 8'h00;
    test_reset();
    test_spi_read();
    test_spi_write_same();
    test_host_read();
    test_host_write_refresh();
    test_back_to_back();
    test_overrun();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
